mips_controller: RTL

- Multicycle control unit for the 8-bit MIPS datapath. Sits at the opposite end of the ALU control interface: it drives alucont into the ALU and consumes the ALU's zero flag.
- Fetches each 32-bit instruction over four byte-wide memory reads. Decodes op/funct and sequences every datapath enable, mux select and ALU operation.

---
 rtl/mips_controller_pkg.sv | 82 ++++++++
 rtl/mips_controller_alu_decoder.sv | 29 ++
 rtl/mips_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_controller_pkg.sv
// Shared constants for the 8-bit multicycle MIPS: opcodes, functs, ALU encodings, FSM states.
// MIPS_BNE_EN adds the BNEEX state for op 000101.
package mips_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCONT_AND = 3'b000;
  localparam logic [2:0] ALUCONT_OR  = 3'b001;
  localparam logic [2:0] ALUCONT_ADD = 3'b010;
  localparam logic [2:0] ALUCONT_SUB = 3'b110;
  localparam logic [2:0] ALUCONT_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
`ifdef MIPS_BNE_EN
    ,
    S_BNEEX   = 4'd15
`endif
  } state_e;

  // Everything the FSM decodes from its state register, before reset gating.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    aluop_e     aluop;
  } ctrl_t;

  // The four fetch states differ only in which instruction-register byte they load.
  function automatic ctrl_t fetch_ctrl(input logic [3:0] byte_en);
    ctrl_t c;
    c         = '0;
    c.memread = 1'b1;
    c.irwrite = byte_en;
    c.alusrcb = 2'b01;
    c.pcwrite = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// ALU decoder: maps the controller's aluop (and funct for R-type) onto the ALU's alucont.
module alu_decoder
  import mips_controller_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucont_o
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    alucont_o = ALUCONT_ADD;
    unique case (aluop_i)
      ALUOP_SUB:   alucont_o = ALUCONT_SUB;
      ALUOP_FUNCT: begin
        unique case (funct_i)
          FUNCT_ADD: alucont_o = ALUCONT_ADD;
          FUNCT_SUB: alucont_o = ALUCONT_SUB;
          FUNCT_AND: alucont_o = ALUCONT_AND;
          FUNCT_OR:  alucont_o = ALUCONT_OR;
          FUNCT_SLT: alucont_o = ALUCONT_SLT;
          default:   alucont_o = ALUCONT_ADD;
        endcase
      end
      default:     alucont_o = ALUCONT_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: byte-wise fetch, decode, and per-instruction sequencing.
// Define MIPS_BNE_EN to support BNE (op 000101) through the BNEEX state.
module mips_controller
  import mips_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucont,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset_n) state_q <= S_FETCH1;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_FETCH1: begin ctrl = fetch_ctrl(4'b0001); state_d = S_FETCH2; end
      S_FETCH2: begin ctrl = fetch_ctrl(4'b0010); state_d = S_FETCH3; end
      S_FETCH3: begin ctrl = fetch_ctrl(4'b0100); state_d = S_FETCH4; end
      S_FETCH4: begin ctrl = fetch_ctrl(4'b1000); state_d = S_DECODE; end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        unique case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = (op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        state_d      = S_LBWR;
      end
      S_LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = S_FETCH1;
      end
      S_SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = S_FETCH1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = S_FETCH1;
      end
      S_BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.branch   = 1'b1;
        ctrl.pcsource = 2'b01;
        state_d       = S_FETCH1;
      end
`ifdef MIPS_BNE_EN
      S_BNEEX: begin
        ctrl.alusrca   = 1'b1;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.branch_ne = 1'b1;
        ctrl.pcsource  = 2'b01;
        state_d        = S_FETCH1;
      end
`endif
      S_JEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = 2'b10;
        state_d       = S_FETCH1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = S_ADDIWR;
      end
      S_ADDIWR: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH1;
      end
      default: state_d = S_FETCH1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i   (ctrl.aluop),
    .funct_i   (funct),
    .alucont_o (alucont)
  );

  // Reset parks the FSM in FETCH1, whose strobes must not reach the datapath while reset_n is low.
  assign pcen     = reset_n & (ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.branch_ne & ~zero));
  assign irwrite  = reset_n ? ctrl.irwrite : 4'b0000;
  assign regwrite = reset_n & ctrl.regwrite;
  assign memwrite = reset_n & ctrl.memwrite;

  assign memread  = ctrl.memread;
  assign iord     = ctrl.iord;
  assign pcsource = ctrl.pcsource;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;

endmodule
